// File: rtl/mult_div_unit.sv
// mult_div_unit: execute-stage multiply/divide unit owning the architectural HI/LO registers.
// Latency: mult/multu busy for MULT_CYCLES and div/divu for DIV_CYCLES, with HI/LO written as busy falls; mthi/mtlo take effect next cycle.
// Backpressure: any start while busy is dropped, since the hazard unit stalls on start|busy.
// Ports: clk, reset (sync, active-high); start/mdop/a/b request; busy, hi, lo registered outputs.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  // Cleared for divide-by-zero so completion leaves HI/LO untouched.
  logic        wr_q, wr_d;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, q_s, r_s;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide done on magnitudes so truncation toward zero and the
  // dividend-signed remainder are explicit and INT_MIN/-1 is well defined.
  assign a_neg   = (mdop == OP_DIV) && a[31];
  assign b_neg   = (mdop == OP_DIV) && b[31];
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;
  assign divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag   = a_mag / divisor;
  assign r_mag   = a_mag % divisor;
  assign q_s     = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign r_s     = a_neg ? -r_mag : r_mag;

  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    wr_d     = wr_q;

    if (cnt_q == 4'd1) begin
      cnt_d = 4'd0;
      if (wr_q) begin
        hi_d = res_hi_q;
        lo_d = res_lo_q;
      end
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end

    // Only reachable with cnt_q == 0, so never collides with completion above.
    if (start && !busy) begin
      case (mdop)
        OP_MULT: begin
          res_hi_d = prod_s[63:32];
          res_lo_d = prod_s[31:0];
          wr_d     = 1'b1;
          cnt_d    = 4'(MULT_CYCLES);
        end
        OP_MULTU: begin
          res_hi_d = prod_u[63:32];
          res_lo_d = prod_u[31:0];
          wr_d     = 1'b1;
          cnt_d    = 4'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          res_hi_d = r_s;
          res_lo_d = q_s;
          wr_d     = (b != 32'd0);
          cnt_d    = 4'(DIV_CYCLES);
        end
        OP_MTHI: hi_d = a;
        OP_MTLO: lo_d = a;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      wr_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      wr_q     <= wr_d;
    end
  end

  assign busy = (cnt_q != 4'd0);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: self-checking bench for mult_div_unit with a HI/LO scoreboard.
// Latency: follows the default MULT_CYCLES=5 / DIV_CYCLES=10 timing.
// Backpressure: exercises start-while-busy being dropped and back-to-back issue.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  // Reference HI/LO and queue of pending multicycle results.
  logic [31:0] hi_m = 32'd0, lo_m = 32'd0;
  logic [31:0] exp_hi_q[$];
  logic [31:0] exp_lo_q[$];

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference result for a multicycle op; divide by zero keeps HI/LO.
  task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el);
    logic signed [63:0] ps;
    logic [63:0] pu;
    eh = hi_m;
    el = lo_m;
    case (op)
      3'd1: begin ps = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); eh = ps[63:32]; el = ps[31:0]; end
      3'd2: begin pu = {32'd0, x} * {32'd0, y}; eh = pu[63:32]; el = pu[31:0]; end
      3'd3: if (y != 0) begin el = $signed(x) / $signed(y); eh = $signed(x) % $signed(y); end
      3'd4: if (y != 0) begin el = x / y; eh = x % y; end
      default: ;
    endcase
  endtask

  // Issue one multicycle op at a negedge, returning at the negedge of the first non-busy cycle.
  task automatic run_mc(input string name, input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y, input int exp_cycles, input bit inject_mtlo);
    logic [31:0] eh, el, ph, pl;
    int n;
    model(op, x, y, eh, el);
    exp_hi_q.push_back(eh);
    exp_lo_q.push_back(el);
    start = 1'b1; mdop = op; a = x; b = y;
    @(negedge clk);
    start = 1'b0; mdop = 3'd0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      checks++;
      if (hi !== hi_m || lo !== lo_m) begin
        errors++;
        $display("FAIL %s_hold cycle %0d: hi=%h lo=%h required hi=%h lo=%h", name, n, hi, lo, hi_m, lo_m);
      end
      if (inject_mtlo && n == 2) begin
        start = 1'b1; mdop = 3'd6; a = 32'hDEADBEEF;
      end else begin
        start = 1'b0; mdop = 3'd0;
      end
      @(negedge clk);
    end
    start = 1'b0; mdop = 3'd0;
    checks++;
    if (n != exp_cycles) begin
      errors++;
      $display("FAIL %s_busy_len: %0d cycles, required %0d", name, n, exp_cycles);
    end
    ph = exp_hi_q.pop_front();
    pl = exp_lo_q.pop_front();
    checks++;
    if (hi !== ph || lo !== pl) begin
      errors++;
      $display("FAIL %s_result: hi=%h lo=%h required hi=%h lo=%h", name, hi, lo, ph, pl);
    end
    hi_m = ph;
    lo_m = pl;
  endtask

  task automatic run_mt(input string name, input logic [2:0] op, input logic [31:0] x);
    start = 1'b1; mdop = op; a = x;
    @(negedge clk);
    start = 1'b0; mdop = 3'd0;
    if (op == 3'd5) hi_m = x; else lo_m = x;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busy !== 1'b0 || hi !== hi_m || lo !== lo_m) begin
        errors++;
        $display("FAIL %s cycle %0d: busy=%b hi=%h lo=%h required busy=0 hi=%h lo=%h",
                 name, i, busy, hi, lo, hi_m, lo_m);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; mdop = 3'd5; a = 32'hFFFF0000; b = 32'd0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0; mdop = 3'd0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
    end
    reset = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_after: busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
    end
  endtask

  task automatic test_mult();
    run_mc("mult", 3'd1, 32'hFFFFFFFF, 32'h00000002, 5, 1'b0);
    run_mc("multu", 3'd2, 32'hFFFFFFFF, 32'h00000002, 5, 1'b0);
  endtask

  task automatic test_div();
    run_mc("div", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 1'b0);
    run_mc("divu", 3'd4, 32'd7, 32'd2, 10, 1'b0);
    run_mc("div_negdivisor", 3'd3, 32'd7, 32'hFFFFFFFE, 10, 1'b0);
  endtask

  task automatic test_div_zero();
    run_mt("mthi", 3'd5, 32'h12345678);
    run_mt("mtlo", 3'd6, 32'h9ABCDEF0);
    run_mc("div0", 3'd3, 32'h00000055, 32'd0, 10, 1'b0);
    run_mc("divu0", 3'd4, 32'hFFFFFFFF, 32'd0, 10, 1'b0);
  endtask

  task automatic test_busy_ignore();
    run_mc("mult_ignore_mtlo", 3'd1, 32'd3, 32'd5, 5, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_mc("b2b_first", 3'd1, 32'd1000, 32'hFFFFFFFD, 5, 1'b0);
    run_mc("b2b_second", 3'd2, 32'h80000000, 32'h80000000, 5, 1'b0);
    run_mc("b2b_div", 3'd4, 32'd100, 32'd7, 10, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    logic [2:0] op;
    for (int i = 0; i < 6; i++) begin
      op = 3'(1 + (i % 4));
      x = $urandom;
      y = $urandom;
      if (op == 3'd3 && x == 32'h80000000 && y == 32'hFFFFFFFF) y = 32'd3;
      run_mc("rand", op, x, y, (op >= 3'd3) ? 10 : 5, 1'b0);
    end
  endtask

  task automatic test_reset_busy();
    run_mt("mthi_pre", 3'd5, 32'hCAFEF00D);
    start = 1'b1; mdop = 3'd4; a = 32'd50; b = 32'd3;
    @(negedge clk);
    start = 1'b0; mdop = 3'd0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rstbusy_pre: busy=%b required 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL rstbusy_abort: busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
        errors++;
        $display("FAIL rstbusy_no_late_write cycle %0d: busy=%b hi=%h lo=%h required 0 0 0", i, busy, hi, lo);
      end
    end
    hi_m = 32'd0; lo_m = 32'd0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mdop = 3'd0; a = 32'd0; b = 32'd0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
